// File: rtl/inst_encoder.sv
// inst_encoder
//   Packs RV32I LW / SW / BEQ instruction words from their fields and the
//   per-format immediate layout. Encoded words queue in a small FIFO and leave
//   with a sequential word address for instruction-memory preload.
//
// Ports
//   clk, rst             clock (rising edge), async active-high reset
//   in_valid / in_ready  field-set handshake (ready = FIFO not full)
//   in_op                00 LW, 01 SW, 10 BEQ, 11 reserved
//   in_rd/in_rs1/in_rs2  register fields
//   in_imm               signed immediate (byte offset for BEQ)
//   out_valid/out_ready  head-of-FIFO handshake
//   out_inst, out_err    encoded word at head and its illegal-field flag
//   out_addr             word address of the head entry
//   err_count            saturating count of popped entries flagged err
module inst_encoder #(
  parameter int DEPTH     = 2,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic              out_err,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] OP_LW  = 2'b00;
  localparam logic [1:0] OP_SW  = 2'b01;
  localparam logic [1:0] OP_BEQ = 2'b10;

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  logic signed [31:0] imm_s;
  logic               ls_legal;
  logic               br_legal;
  logic [12:0]        imm_eff;
  logic [31:0]        enc_inst;
  logic               enc_err;

  assign imm_s    = in_imm;
  assign ls_legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign br_legal = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];

  always_comb begin
    imm_eff  = '0;
    enc_inst = 32'h0000_0013;
    enc_err  = 1'b1;
    unique case (in_op)
      OP_LW: begin
        enc_err  = !ls_legal;
        imm_eff  = ls_legal ? in_imm[12:0] : '0;
        enc_inst = {imm_eff[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      end
      OP_SW: begin
        enc_err  = !ls_legal;
        imm_eff  = ls_legal ? in_imm[12:0] : '0;
        enc_inst = {imm_eff[11:5], in_rs2, in_rs1, 3'b010, imm_eff[4:0], 7'b0100011};
      end
      OP_BEQ: begin
        enc_err  = !br_legal;
        imm_eff  = br_legal ? in_imm[12:0] : '0;
        enc_inst = {imm_eff[12], imm_eff[10:5], in_rs2, in_rs1, 3'b000,
                    imm_eff[4:1], imm_eff[11], 7'b1100011};
      end
      default: begin
        // reserved op: emit a NOP so a preload never executes garbage
        enc_inst = 32'h0000_0013;
        enc_err  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO of {err, inst}
  // ---------------------------------------------------------------------------
  logic [32:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              full;
  logic              push;
  logic              pop;

  // ready depends only on the stored count: a pop in the same cycle does not
  // free a slot for the incoming push.
  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // head fields are gated so an empty FIFO always shows zeros
  assign out_inst  = out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
  assign out_err   = out_valid ? mem_q[rd_ptr_q][32]   : 1'b0;
  assign out_addr  = addr_q;
  assign err_count = err_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    addr_d    = addr_q;
    err_cnt_d = err_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      addr_d   = addr_q + ADDR_W'(1);
      if (mem_q[rd_ptr_q][32] && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end
    if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (!push && pop) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= ADDR_W'(BASE_ADDR);
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // storage needs no reset: entries are only visible while counted valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {enc_err, enc_inst};
  end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  localparam int         DEPTH = 2;
  localparam int         AW    = 2;
  localparam logic [1:0] BASE  = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [AW-1:0] out_addr;
  logic [7:0]  err_count;

  inst_encoder #(.DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(int'(BASE))) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .out_addr(out_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } ent_t;

  ent_t        q[$];
  logic [AW-1:0] exp_addr;
  int          exp_cnt;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: place immediate bits by plain arithmetic from the format rules.
  function automatic ent_t ref_enc(input logic [1:0] op, input int rd, input int rs1,
                                   input int rs2, input int imm);
    ent_t e;
    int   i;
    int   u;
    bit   legal;
    case (op)
      2'd0, 2'd1: begin
        legal = (imm >= -2048) && (imm <= 2047);
        i = legal ? imm : 0;
        u = i & 'hFFF;
        if (op == 2'd0)
          e.inst = 32'(u * (2**20) + rs1 * (2**15) + 2 * (2**12) + rd * (2**7) + 3);
        else
          e.inst = 32'((u / 32) * (2**25) + rs2 * (2**20) + rs1 * (2**15) + 2 * (2**12)
                       + (u % 32) * (2**7) + 'h23);
      end
      2'd2: begin
        legal = (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
        i = legal ? imm : 0;
        u = i & 'h1FFF;
        e.inst = 32'(((u / 4096) % 2) * (2**31) + ((u / 32) % 64) * (2**25)
                     + rs2 * (2**20) + rs1 * (2**15) + ((u / 2) % 16) * (2**8)
                     + ((u / 2048) % 2) * (2**7) + 'h63);
      end
      default: begin
        legal = 1'b0;
        e.inst = 32'h13;
      end
    endcase
    e.err = !legal;
    return e;
  endfunction

  // Called just after a falling edge with inputs already set.
  task automatic step();
    bit   push, pop;
    ent_t e;
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
    chk("out_addr",  32'(out_addr),  32'(exp_addr));
    chk("err_count", 32'(err_count), 32'(exp_cnt));
    if (q.size() > 0) begin
      chk("out_inst", out_inst, q[0].inst);
      chk("out_err",  32'(out_err), 32'(q[0].err));
    end else begin
      chk("empty_inst", out_inst, 32'h0);
    end
    push = in_valid && (q.size() < DEPTH);
    pop  = (q.size() > 0) && out_ready;
    e = ref_enc(in_op, int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_imm));
    @(posedge clk);
    if (pop) begin
      if (q[0].err && exp_cnt < 255) exp_cnt++;
      q.delete(0);
      exp_addr = exp_addr + 1'b1;
    end
    if (push) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_fields(input logic [1:0] op, input int rd, input int rs1,
                            input int rs2, input int imm);
    in_op = op; in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 32'(imm);
  endtask

  // single entry into an empty FIFO, compared with a hand-computed word
  task automatic kat(input string tag, input logic [1:0] op, input int rd, input int rs1,
                     input int rs2, input int imm, input logic [31:0] w, input logic er);
    set_fields(op, rd, rs1, rs2, imm);
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk({tag, "_inst"}, out_inst, w);
    chk({tag, "_err"}, 32'(out_err), 32'(er));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  int bnd [14] = '{-4097, -4096, -4095, -2049, -2048, -1, 0, 3, 6, 2047, 2048, 4094, 4095, 4096};

  function automatic int rand_imm();
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(0, 10000)) - 5000;
      1:       return bnd[$urandom_range(0, 13)];
      default: return int'($urandom());
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(2'd0, 0, 0, 0, 0);
    exp_addr = BASE; exp_cnt = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_inst",  out_inst, 32'h0);
    chk("rst_err",   32'(out_err), 32'd0);
    chk("rst_addr",  32'(out_addr), 32'(BASE));
    chk("rst_cnt",   32'(err_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    kat("t1_lw",     2'd0, 5, 2, 0, 8,    32'h00812283, 1'b0);
    kat("t2_sw",     2'd1, 0, 2, 6, -4,   32'hFE612E23, 1'b0);
    kat("t2_beq",    2'd2, 0, 1, 2, -8,   32'hFE208CE3, 1'b0);
    kat("t3_lw_big", 2'd0, 5, 2, 9, 2048, 32'h00012283, 1'b1);
    kat("t3_beq6",   2'd2, 0, 1, 2, 6,    32'h00208363, 1'b0);
    kat("t3_beq3",   2'd2, 0, 1, 2, 3,    32'h00208063, 1'b1);
    kat("t3_rsvd",   2'd3, 7, 7, 7, 1,    32'h00000013, 1'b1);
    chk("t3_errcnt", 32'(err_count), 32'd3);

    // back-pressure: third push must wait until a slot frees
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_fields(2'd0, k + 1, k + 2, 0, k * 4);
      step();
    end
    chk("t4_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();

    // reset with two entries queued and both handshakes active
    out_ready = 1'b0; in_valid = 1'b1;
    set_fields(2'd1, 0, 3, 4, 100);
    step(); step();
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_addr",  32'(out_addr), 32'(BASE));
    chk("t6_cnt",   32'(err_count), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    q.delete(); exp_addr = BASE; exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    kat("t6_after", 2'd0, 5, 2, 0, 8, 32'h00812283, 1'b0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      set_fields(2'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), rand_imm());
      step();
    end

    // stream reserved ops to drive err_count into saturation
    out_ready = 1'b1; in_valid = 1'b1;
    set_fields(2'd3, 0, 0, 0, 0);
    for (int n = 0; n < 560; n++) step();
    chk("sat_cnt", 32'(err_count), 32'd255);
    in_valid = 1'b0;
    for (int n = 0; n < 3; n++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
